div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle iterative restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits beside the ALU in the EX stage.
- Each step is a conditional subtract: the inverse of the ripple-carry add path.
- Stalls the pipeline via busy and delivers the result with a one-cycle done pulse.

Parameters:
- N, 32, operand/result width (XLEN); must be even and at least 4.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  in  N  rs1 value
- divisor  in  N  rs2 value
- flush  in  1  abort in-flight operation (branch mispredict or trap)
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse; result is valid in that cycle
- result  out  N  quotient or remainder, registered

Behaviour:
- States: IDLE, CALC, DONE. Iteration counter is log2(N)+1 bits wide.
- Reset (rst=1 at a clock edge, any state including mid-operation):
  - state=IDLE; busy=0, done=0, result=0.
  - Counter and working registers cleared.
- IDLE:
  - If start=1 at the edge ending cycle T: latch op, sign flags, |dividend| and |divisor|. Abs is taken only for DIV/REM; unsigned ops pass operands raw.
  - Then clear remainder accumulator and counter; go to CALC.
- CALC, one restoring step per cycle:
  - Shift {rem, quo} left by 1.
  - Trial = rem - divisor (N+1 bits).
  - If trial is non-negative: rem = trial and quo[0] = 1. Otherwise rem is unchanged and quo[0] = 0.
  - After N steps (cycles T+1..T+N) go to DONE.
- Final correction is applied on the edge entering DONE:
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - result selects quotient for op[1]=0 and remainder for op[1]=1.
- DONE: done=1 for exactly one cycle (T+N+1), then go to IDLE.
- Latency: start in cycle T gives done in cycle T+N+1 (T+33 at N=32). busy is high in T+1..T+N+1.
- result holds its value until the next completion or reset. It is not cleared on start.
- start while busy is ignored; no queueing.
- flush=1 in CALC or DONE: go to IDLE at that edge, and done is suppressed that cycle. flush in IDLE has no effect. rst takes priority over flush.
- start and flush both high in IDLE: start is accepted.
- RISC-V special cases (no trap):
  - Divisor=0: quotient is all ones (DIV and DIVU); remainder = dividend.
  - DIV overflow (dividend=1<<(N-1), divisor=all ones): quotient = dividend, remainder = 0.
  - Both cases are detected at start and force the correction stage. Timing is unchanged unless the optional feature below is enabled.

Optional Feature:
- Macro: DIV_UNIT_EARLY_OUT_EN.
- Defined: divide-by-zero and overflow cases skip CALC. IDLE goes directly to DONE, so done is in cycle T+1 with the special-case result.
- Undefined: all operations take the full N+1 cycle latency. Results are identical in both builds.

Decomposition:
- Shared package holds:
  - op encodings (OP_DIV, OP_DIVU, OP_REM, OP_REMU).
  - State enum (S_IDLE, S_CALC, S_DONE).
  - XLEN=32 constant.
- One natural sub-module, div_step: combinational, one restoring step.
  - Inputs: rem, quo MSB, divisor.
  - Outputs: next rem, quotient bit.
  - Built on an N+1-bit subtract (adder with inverted divisor, cin=1).

Test Plan:
- DIVU 100/7, start at T: result=14 with done at T+33; REMU gives 2. busy high T+1..T+33.
- Signed rounding:
  - DIV -7/2 = 0xFFFFFFFD.
  - REM -7/2 = 0xFFFFFFFF.
  - DIV 7/-2 = 0xFFFFFFFD.
  - REM 7/-2 = 0x00000001.
- Divide by zero:
  - DIVU 5/0 = 0xFFFFFFFF.
  - REMU 5/0 = 5.
  - DIV -5/0 = 0xFFFFFFFF.
  - REM -5/0 = 0xFFFFFFFB.
- Overflow: DIV 0x80000000/0xFFFFFFFF = 0x80000000; REM of the same operands = 0.
- Control sequencing:
  - Start at T, second start at T+5 with other operands: ignored, first result returned.
  - Flush at T+10: busy low at T+11, no done pulse, result unchanged.
  - rst at T+20: all outputs 0 next cycle.
- With DIV_UNIT_EARLY_OUT_EN defined: DIVU 5/0 gives done at T+1, result 0xFFFFFFFF. Normal DIVU 100/7 still completes at T+33.

Source files
------------

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the iterative RV32M divider.
//   XLEN        - default operand/result width
//   div_op_e    - funct3[1:0] encodings for DIV / DIVU / REM / REMU
//   div_state_e - divider sequencing states
package div_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/div_unit_step.sv
// div_step: one combinational restoring-division step.
// Ports:
//   rem      in  N  partial remainder (always < divisor)
//   quo_msb  in  1  next dividend bit shifted into the remainder
//   divisor  in  N  |divisor|
//   rem_next out N  updated partial remainder
//   quo_bit  out 1  quotient bit produced by this step
module div_step
    import div_unit_pkg::*;
#(
    parameter int N = XLEN
) (
    input  logic [N-1:0] rem,
    input  logic         quo_msb,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_next,
    output logic         quo_bit
);

    logic [N:0] shifted_s;
    logic [N:0] trial_s;

    // Since rem < divisor, shifted - divisor always fits in N+1 signed bits,
    // so the top bit of the trial is a reliable sign.
    assign shifted_s = {rem, quo_msb};
    assign trial_s   = shifted_s + {1'b1, ~divisor} + {{N{1'b0}}, 1'b1};
    assign quo_bit   = ~trial_s[N];
    assign rem_next  = quo_bit ? trial_s[N-1:0] : shifted_s[N-1:0];

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// Ports:
//   clk, rst  - rising-edge clock, synchronous active-high reset
//   start     - request, sampled only in IDLE
//   op        - funct3[1:0] (00 DIV, 01 DIVU, 10 REM, 11 REMU)
//   dividend  - rs1, divisor - rs2
//   flush     - abort an in-flight operation
//   busy      - high whenever not IDLE
//   done      - one-cycle completion pulse, result valid that cycle
//   result    - registered quotient or remainder
// Optional build macro DIV_UNIT_EARLY_OUT_EN: divide-by-zero and signed
// overflow go straight from IDLE to DONE (done one cycle after start).
module div_unit
    import div_unit_pkg::*;
#(
    parameter int N = XLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result
);

    localparam int            CW        = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  ONE       = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  MIN_NEG   = {1'b1, {(N-1){1'b0}}};

    // RISC-V defined results for divide-by-zero and signed overflow.
    function automatic logic [N-1:0] special_result(input logic [1:0]   f_op,
                                                    input logic [N-1:0] f_dvnd,
                                                    input logic         f_divz);
        logic [N-1:0] res;
        if (f_divz) begin
            res = f_op[1] ? f_dvnd : {N{1'b1}};
        end else begin
            res = f_op[1] ? {N{1'b0}} : f_dvnd;
        end
        return res;
    endfunction

    div_state_e    state_r, state_next_s;
    logic [CW-1:0] cnt_r;
    logic [1:0]    op_r;
    logic          neg_q_r, neg_r_r, divz_r, ovf_r;
    logic [N-1:0]  rem_r, quo_r, dvsr_r, dvnd_raw_r, result_r;

    logic          signed_op_s, divz_in_s, ovf_in_s;
    logic [N-1:0]  abs_dvnd_s, abs_dvsr_s;
    logic          accept_s, step_s, finish_s;
    logic [N-1:0]  rem_step_s, quo_fin_s, quo_cor_s, rem_cor_s, final_s;
    logic          qbit_s;

    assign signed_op_s = (op == OP_DIV) || (op == OP_REM);
    assign divz_in_s   = (divisor == {N{1'b0}});
    assign ovf_in_s    = signed_op_s && (dividend == MIN_NEG) && (divisor == {N{1'b1}});
    assign abs_dvnd_s  = (signed_op_s && dividend[N-1]) ? (~dividend + ONE) : dividend;
    assign abs_dvsr_s  = (signed_op_s && divisor[N-1])  ? (~divisor + ONE)  : divisor;

`ifdef DIV_UNIT_EARLY_OUT_EN
    logic special_in_s;
    assign special_in_s = divz_in_s || ovf_in_s;
`endif

    div_step #(.N(N)) u_step (
        .rem      (rem_r),
        .quo_msb  (quo_r[N-1]),
        .divisor  (dvsr_r),
        .rem_next (rem_step_s),
        .quo_bit  (qbit_s)
    );

    // Sign correction uses the last step's outputs directly so the result is
    // registered on the same edge that enters DONE.
    assign quo_fin_s = {quo_r[N-2:0], qbit_s};
    assign quo_cor_s = neg_q_r ? (~quo_fin_s + ONE) : quo_fin_s;
    assign rem_cor_s = neg_r_r ? (~rem_step_s + ONE) : rem_step_s;
    assign final_s   = (divz_r || ovf_r) ? special_result(op_r, dvnd_raw_r, divz_r)
                                         : (op_r[1] ? rem_cor_s : quo_cor_s);

    // Next-state and step-control decode.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        finish_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    accept_s = 1'b1;
`ifdef DIV_UNIT_EARLY_OUT_EN
                    if (special_in_s) begin
                        state_next_s = S_DONE;
                    end else begin
                        state_next_s = S_CALC;
                    end
`else
                    state_next_s = S_CALC;
`endif
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_next_s = S_IDLE;
                end else begin
                    step_s = 1'b1;
                    if (cnt_r == LAST_STEP) begin
                        finish_s     = 1'b1;
                        state_next_s = S_DONE;
                    end else begin
                        state_next_s = S_CALC;
                    end
                end
            end
            S_DONE:  state_next_s = S_IDLE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // State, working registers and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            cnt_r      <= {CW{1'b0}};
            op_r       <= 2'b00;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            divz_r     <= 1'b0;
            ovf_r      <= 1'b0;
            rem_r      <= {N{1'b0}};
            quo_r      <= {N{1'b0}};
            dvsr_r     <= {N{1'b0}};
            dvnd_raw_r <= {N{1'b0}};
            result_r   <= {N{1'b0}};
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                op_r       <= op;
                neg_q_r    <= signed_op_s && (dividend[N-1] ^ divisor[N-1]);
                neg_r_r    <= signed_op_s && dividend[N-1];
                divz_r     <= divz_in_s;
                ovf_r      <= ovf_in_s;
                dvnd_raw_r <= dividend;
                dvsr_r     <= abs_dvsr_s;
                quo_r      <= abs_dvnd_s;
                rem_r      <= {N{1'b0}};
                cnt_r      <= {CW{1'b0}};
            end else if (step_s) begin
                rem_r <= rem_step_s;
                quo_r <= quo_fin_s;
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
            if (finish_s) begin
                result_r <= final_s;
`ifdef DIV_UNIT_EARLY_OUT_EN
            end else if (accept_s && special_in_s) begin
                result_r <= special_result(op, dividend, divz_in_s);
`endif
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign busy   = (state_r != S_IDLE);
    // A flush during the DONE cycle cancels the pulse.
    assign done   = (state_r == S_DONE) && !flush;
    assign result = result_r;

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [1:0]  op;
    logic [31:0] dividend, divisor;
    logic        busy, done;
    logic [31:0] result;

    always #5 clk = ~clk;

    div_unit #(.N(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

`ifdef DIV_UNIT_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif
    localparam int NORMAL_LAT = 33;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        special;
    } vec_t;

    vec_t vecs[20];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Issue one operation and wait (bounded) for the done pulse.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic fl, output logic [31:0] res, output int lat,
                          output int busy_bad);
        @(negedge clk);
        op = o; dividend = a; divisor = b; start = 1'b1; flush = fl;
        lat = 0; busy_bad = 0; res = 32'hDEADBEEF;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = 1'b0; flush = 1'b0;
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                lat = k;
                res = result;
                break;
            end
        end
    endtask

    logic [31:0] res;
    int          lat, busy_bad, exp_lat, saw_done;

    initial begin
        vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         1'b0};
        vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          1'b0};
        vecs[2]  = '{2'b00, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   1'b0};
        vecs[3]  = '{2'b10, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   1'b0};
        vecs[4]  = '{2'b00, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   1'b0};
        vecs[5]  = '{2'b10, 32'd7,          32'hFFFFFFFE,   32'h00000001,   1'b0};
        vecs[6]  = '{2'b01, 32'd5,          32'd0,          32'hFFFFFFFF,   1'b1};
        vecs[7]  = '{2'b11, 32'd5,          32'd0,          32'd5,          1'b1};
        vecs[8]  = '{2'b00, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFF,   1'b1};
        vecs[9]  = '{2'b10, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   1'b1};
        vecs[10] = '{2'b00, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b1};
        vecs[11] = '{2'b10, 32'h80000000,   32'hFFFFFFFF,   32'h00000000,   1'b1};
        vecs[12] = '{2'b00, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E,   1'b0};
        vecs[13] = '{2'b10, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   1'b0};
        vecs[14] = '{2'b01, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   1'b0};
        vecs[15] = '{2'b11, 32'hFFFFFFFF,   32'd10,         32'd5,          1'b0};
        vecs[16] = '{2'b01, 32'd7,          32'd100,        32'd0,          1'b0};
        vecs[17] = '{2'b11, 32'd7,          32'd100,        32'd7,          1'b0};
        vecs[18] = '{2'b00, 32'h80000000,   32'd1,          32'h80000000,   1'b0};
        vecs[19] = '{2'b01, 32'h80000000,   32'hFFFFFFFF,   32'd0,          1'b0};

        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00;
        dividend = 32'd0; divisor = 32'd0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, res, lat, busy_bad);
            exp_lat = vecs[i].special ? SPECIAL_LAT : NORMAL_LAT;
            check($sformatf("vec%0d result", i), res, vecs[i].exp);
            check($sformatf("vec%0d latency", i), lat, exp_lat);
            check($sformatf("vec%0d busy", i), busy_bad, 32'd0);
            @(negedge clk);
            check($sformatf("vec%0d idle after", i), {30'd0, busy, done}, 32'd0);
        end

        // Second start at T+5 is ignored.
        @(negedge clk);
        op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 5) begin
                op = 2'b01; dividend = 32'd50; divisor = 32'd5; start = 1'b1;
            end
            if (done === 1'b1) begin
                lat = k;
                res = result;
                break;
            end
        end
        check("restart ignored result", res, 32'd14);
        check("restart ignored latency", lat, NORMAL_LAT);
        start = 1'b0;
        saw_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) saw_done++;
        end
        check("restart no extra done", saw_done, 32'd0);

        // Flush at T+10: idle at T+11, no done, result unchanged.
        @(negedge clk);
        op = 2'b01; dividend = 32'd200; divisor = 32'd3; start = 1'b1;
        saw_done = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            start = 1'b0;
            flush = (k == 10);
            if (k == 11) check("flush busy low", {31'd0, busy}, 32'd0);
            if (done === 1'b1) saw_done++;
        end
        flush = 1'b0;
        check("flush no done", saw_done, 32'd0);
        check("flush result held", result, 32'd14);

        // Flush during the DONE cycle suppresses the pulse.
        @(negedge clk);
        op = 2'b01; dividend = 32'd9; divisor = 32'd3; start = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        flush = 1'b1;
        #1;
        check("flush in done: done", {31'd0, done}, 32'd0);
        check("flush in done: busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        flush = 1'b0;
        check("flush in done: idle", {30'd0, busy, done}, 32'd0);

        // start and flush together in IDLE: start wins.
        run_op(2'b00, 32'hFFFFFFF9, 32'd2, 1'b1, res, lat, busy_bad);
        check("start+flush result", res, 32'hFFFFFFFD);
        check("start+flush latency", lat, NORMAL_LAT);
        @(negedge clk);

        // Reset at T+20 clears everything next cycle.
        op = 2'b01; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 20) rst = 1'b1;
            if (k == 21) begin
                check("mid-op reset busy", {31'd0, busy}, 32'd0);
                check("mid-op reset done", {31'd0, done}, 32'd0);
                check("mid-op reset result", result, 32'd0);
            end
        end
        rst = 1'b0;

        run_op(2'b11, 32'd100, 32'd7, 1'b0, res, lat, busy_bad);
        check("post-reset result", res, 32'd2);
        check("post-reset latency", lat, NORMAL_LAT);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
